// File: rtl/sm_mem_arbiter_if.sv
// rtl/sm_mem_arbiter_if.sv - requester/slave bus bundle for sm_mem_arbiter (err present with SM_ARB_TIMEOUT_EN)
interface sm_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic                  m0_ack;
  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [31:0]           m1_wdata;
  logic                  m1_ack;
  logic [31:0]           m_rdata;
  logic                  s_req;
  logic                  s_we;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [31:0]           s_wdata;
  logic [31:0]           s_rdata;
  logic                  s_ack;
  logic                  grant_id;
`ifdef SM_ARB_TIMEOUT_EN
  logic                  err;
`endif

  // master: the arbiter, which owns the memory-side request and the requester acks
  modport master (
    input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, s_rdata, s_ack,
    output m0_ack, m1_ack, m_rdata, s_req, s_we, s_addr, s_wdata, grant_id
`ifdef SM_ARB_TIMEOUT_EN
    , output err
`endif
  );

  modport slave (
    output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, s_rdata, s_ack,
    input  m0_ack, m1_ack, m_rdata, s_req, s_we, s_addr, s_wdata, grant_id
`ifdef SM_ARB_TIMEOUT_EN
    , input err
`endif
  );
endinterface

// File: rtl/sm_mem_arbiter.sv
// rtl/sm_mem_arbiter.sv - round-robin fetch/data arbiter onto one memory slave, one access in flight
// Optional ack watchdog and sticky err output enabled by SM_ARB_TIMEOUT_EN.
module sm_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic            clk,
  input logic            rst_n,
  sm_mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_s_req, w_s_req_nxt;
  logic                  r_s_we, w_s_we_nxt;
  logic [ADDR_WIDTH-1:0] r_s_addr, w_s_addr_nxt;
  logic [31:0]           r_s_wdata, w_s_wdata_nxt;
  logic                  r_m0_ack, w_m0_ack_nxt;
  logic                  r_m1_ack, w_m1_ack_nxt;
  logic [31:0]           r_m_rdata, w_m_rdata_nxt;
  logic                  r_grant_id, w_grant_id_nxt;
  logic                  r_last_grant, w_last_grant_nxt;
  logic                  w_pick_m1;

`ifdef SM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_err, w_err_nxt;
`endif

  // On a tie the requester that did not win last time goes next
  assign w_pick_m1 = (bus.m0_req && bus.m1_req) ? ~r_last_grant : bus.m1_req;

  always_comb begin
    w_state_nxt      = r_state;
    w_s_req_nxt      = r_s_req;
    w_s_we_nxt       = r_s_we;
    w_s_addr_nxt     = r_s_addr;
    w_s_wdata_nxt    = r_s_wdata;
    w_m0_ack_nxt     = 1'b0;
    w_m1_ack_nxt     = 1'b0;
    w_m_rdata_nxt    = r_m_rdata;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
`ifdef SM_ARB_TIMEOUT_EN
    w_cnt_nxt        = r_cnt;
    w_err_nxt        = r_err;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          w_s_req_nxt      = 1'b1;
          w_s_we_nxt       = w_pick_m1 ? bus.m1_we : 1'b0;
          w_s_addr_nxt     = w_pick_m1 ? bus.m1_addr : bus.m0_addr;
          w_s_wdata_nxt    = bus.m1_wdata;
          w_grant_id_nxt   = w_pick_m1;
          w_last_grant_nxt = w_pick_m1;
          w_state_nxt      = ST_BUSY;
`ifdef SM_ARB_TIMEOUT_EN
          w_cnt_nxt        = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (bus.s_ack) begin
          w_s_req_nxt  = 1'b0;
          w_s_we_nxt   = 1'b0;
          w_m0_ack_nxt = ~r_grant_id;
          w_m1_ack_nxt = r_grant_id;
          if (!r_s_we) w_m_rdata_nxt = bus.s_rdata;
          w_state_nxt  = ST_DONE;
        end
`ifdef SM_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_s_req_nxt  = 1'b0;
          w_s_we_nxt   = 1'b0;
          w_m0_ack_nxt = ~r_grant_id;
          w_m1_ack_nxt = r_grant_id;
          if (!r_s_we) w_m_rdata_nxt = 32'hDEAD_BEEF;
          w_err_nxt    = 1'b1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      // Requester is still withdrawing req here, so no arbitration
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_s_req      <= 1'b0;
      r_s_we       <= 1'b0;
      r_s_addr     <= '0;
      r_s_wdata    <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m_rdata    <= '0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
`ifdef SM_ARB_TIMEOUT_EN
      r_cnt        <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_s_req      <= w_s_req_nxt;
      r_s_we       <= w_s_we_nxt;
      r_s_addr     <= w_s_addr_nxt;
      r_s_wdata    <= w_s_wdata_nxt;
      r_m0_ack     <= w_m0_ack_nxt;
      r_m1_ack     <= w_m1_ack_nxt;
      r_m_rdata    <= w_m_rdata_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_last_grant <= w_last_grant_nxt;
`ifdef SM_ARB_TIMEOUT_EN
      r_cnt        <= w_cnt_nxt;
      r_err        <= w_err_nxt;
`endif
    end
  end

  assign bus.s_req    = r_s_req;
  assign bus.s_we     = r_s_we;
  assign bus.s_addr   = r_s_addr;
  assign bus.s_wdata  = r_s_wdata;
  assign bus.m0_ack   = r_m0_ack;
  assign bus.m1_ack   = r_m1_ack;
  assign bus.m_rdata  = r_m_rdata;
  assign bus.grant_id = r_grant_id;
`ifdef SM_ARB_TIMEOUT_EN
  assign bus.err      = r_err;
`endif
endmodule

// File: tb/tb_sm_mem_arbiter.sv
// tb/tb_sm_mem_arbiter.sv - directed self-checking bench for sm_mem_arbiter (timeout case with SM_ARB_TIMEOUT_EN)
module tb_sm_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  sm_mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  sm_mem_arbiter #(.ADDR_WIDTH(32), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.m0_req = 1'b0; bus.m0_addr = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.s_rdata = '0; bus.s_ack = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_rdata = 32'h0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    step();
    n_chk++; if ({bus.s_req, bus.s_we, bus.m0_ack, bus.m1_ack, bus.grant_id} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl got=%b exp=00000", {bus.s_req, bus.s_we, bus.m0_ack, bus.m1_ack, bus.grant_id}); end
    n_chk++; if (bus.s_addr !== 32'h0 || bus.s_wdata !== 32'h0 || bus.m_rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", bus.s_addr, bus.s_wdata, bus.m_rdata); end
`ifdef SM_ARB_TIMEOUT_EN
    n_chk++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
`endif
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read;
    bus.m0_req = 1'b1; bus.m0_addr = 32'h10;
    step();
    n_chk++; if (bus.s_req !== 1'b1 || bus.s_we !== 1'b0 || bus.s_addr !== 32'h10 || bus.grant_id !== 1'b0) begin
      n_bad++; $display("FAIL rd_issue got=req%b we%b addr%h gid%b exp=req1 we0 addr10 gid0", bus.s_req, bus.s_we, bus.s_addr, bus.grant_id); end
    bus.s_ack = 1'b1; bus.s_rdata = 32'h2402_0005;
    step();
    n_chk++; if (bus.m0_ack !== 1'b1 || bus.m1_ack !== 1'b0 || bus.s_req !== 1'b0) begin
      n_bad++; $display("FAIL rd_ack got=a0%b a1%b req%b exp=a0 1 a1 0 req0", bus.m0_ack, bus.m1_ack, bus.s_req); end
    n_chk++; if (bus.m_rdata !== 32'h2402_0005) begin n_bad++; $display("FAIL rd_data got=%h exp=24020005", bus.m_rdata); end
    exp_rdata = 32'h2402_0005;
    bus.m0_req = 1'b0; bus.s_ack = 1'b0;
    step();
    n_chk++; if (bus.m0_ack !== 1'b0 || bus.s_req !== 1'b0) begin
      n_bad++; $display("FAIL rd_done got=a0%b req%b exp=a0 0 req0", bus.m0_ack, bus.s_req); end
  endtask

  task automatic test_round_robin;
    do_reset();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h100;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h200;
    bus.s_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      bus.s_rdata = 32'hA5A5_0000 + 32'(k);
      n_chk++; if (bus.s_req !== 1'b1 || bus.grant_id !== k[0] || bus.s_addr !== (k[0] ? 32'h200 : 32'h100)) begin
        n_bad++; $display("FAIL rr_grant%0d got=req%b gid%b addr%h exp=req1 gid%b", k, bus.s_req, bus.grant_id, bus.s_addr, k[0]); end
      step();
      n_chk++; if (bus.m0_ack !== ~k[0] || bus.m1_ack !== k[0] || bus.m_rdata !== 32'hA5A5_0000 + 32'(k)) begin
        n_bad++; $display("FAIL rr_ack%0d got=a0%b a1%b d%h exp=a0%b a1%b d%h", k, bus.m0_ack, bus.m1_ack, bus.m_rdata, ~k[0], k[0], 32'hA5A5_0000 + 32'(k)); end
      step();
      n_chk++; if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.s_req !== 1'b0) begin
        n_bad++; $display("FAIL rr_gap%0d got=a0%b a1%b req%b exp=0 0 0", k, bus.m0_ack, bus.m1_ack, bus.s_req); end
    end
    exp_rdata = 32'hA5A5_0003;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.s_ack = 1'b0;
    step();
    n_chk++; if (bus.s_req !== 1'b0) begin n_bad++; $display("FAIL rr_drop got=%b exp=0", bus.s_req); end
  endtask

  task automatic test_write_wait;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'hCAFE_F00D;
    bus.s_rdata = 32'h7777_7777;
    for (int c = 1; c <= 5; c++) begin
      step();
      n_chk++; if (bus.s_req !== 1'b1 || bus.s_we !== 1'b1 || bus.s_addr !== 32'h20 || bus.s_wdata !== 32'hCAFE_F00D || bus.m1_ack !== 1'b0) begin
        n_bad++; $display("FAIL wr_hold%0d got=req%b we%b a%h d%h ack%b exp=1 1 20 cafef00d 0", c, bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata, bus.m1_ack); end
      if (c == 5) bus.s_ack = 1'b1;
    end
    step();
    n_chk++; if (bus.m1_ack !== 1'b1 || bus.m0_ack !== 1'b0 || bus.s_req !== 1'b0 || bus.s_we !== 1'b0 || bus.grant_id !== 1'b1) begin
      n_bad++; $display("FAIL wr_ack got=a1%b a0%b req%b we%b gid%b exp=1 0 0 0 1", bus.m1_ack, bus.m0_ack, bus.s_req, bus.s_we, bus.grant_id); end
    n_chk++; if (bus.m_rdata !== exp_rdata) begin n_bad++; $display("FAIL wr_rdata got=%h exp=%h", bus.m_rdata, exp_rdata); end
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.s_ack = 1'b0;
    step();
    n_chk++; if (bus.m1_ack !== 1'b0) begin n_bad++; $display("FAIL wr_pulse got=%b exp=0", bus.m1_ack); end
  endtask

  task automatic test_reset_mid;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h30;
    step();
    n_chk++; if (bus.s_req !== 1'b1 || bus.grant_id !== 1'b1) begin
      n_bad++; $display("FAIL mid_busy got=req%b gid%b exp=1 1", bus.s_req, bus.grant_id); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.s_req !== 1'b0 || bus.grant_id !== 1'b0 || bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.m_rdata !== 32'h0 || bus.s_addr !== 32'h0) begin
      n_bad++; $display("FAIL mid_rst got=req%b gid%b a%b%b d%h addr%h exp=all 0", bus.s_req, bus.grant_id, bus.m0_ack, bus.m1_ack, bus.m_rdata, bus.s_addr); end
    exp_rdata = 32'h0;
    bus.m0_req = 1'b1; bus.m0_addr = 32'h40;
    #2 rst_n = 1'b1;
    step();
    n_chk++; if (bus.s_req !== 1'b1 || bus.grant_id !== 1'b0 || bus.s_addr !== 32'h40) begin
      n_bad++; $display("FAIL mid_tie got=req%b gid%b addr%h exp=1 0 40", bus.s_req, bus.grant_id, bus.s_addr); end
    bus.m1_req = 1'b0;
    bus.s_ack = 1'b1; bus.s_rdata = 32'h0BAD_F00D;
    step();
    n_chk++; if (bus.m0_ack !== 1'b1 || bus.m_rdata !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL mid_ack got=a0%b d%h exp=1 0badf00d", bus.m0_ack, bus.m_rdata); end
    exp_rdata = 32'h0BAD_F00D;
    bus.m0_req = 1'b0; bus.s_ack = 1'b0;
    step();
  endtask

  task automatic test_idle_ack;
    bus.s_ack = 1'b1; bus.s_rdata = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++; if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.s_req !== 1'b0 || bus.m_rdata !== exp_rdata) begin
        n_bad++; $display("FAIL idle_ack%0d got=a%b%b req%b d%h exp=0 0 0 %h", c, bus.m0_ack, bus.m1_ack, bus.s_req, bus.m_rdata, exp_rdata); end
    end
    bus.s_ack = 1'b0;
    bus.m0_req = 1'b1; bus.m0_addr = 32'h50;
    step();
    n_chk++; if (bus.s_req !== 1'b1 || bus.s_addr !== 32'h50 || bus.grant_id !== 1'b0) begin
      n_bad++; $display("FAIL idle_then_req got=req%b addr%h gid%b exp=1 50 0", bus.s_req, bus.s_addr, bus.grant_id); end
    bus.s_ack = 1'b1;
    step();
    n_chk++; if (bus.m0_ack !== 1'b1 || bus.m_rdata !== 32'h1234_5678) begin
      n_bad++; $display("FAIL idle_then_ack got=a0%b d%h exp=1 12345678", bus.m0_ack, bus.m_rdata); end
    exp_rdata = 32'h1234_5678;
    bus.m0_req = 1'b0; bus.s_ack = 1'b0;
    step();
  endtask

`ifdef SM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    n_chk++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL to_err_pre got=%b exp=0", bus.err); end
    bus.m0_req = 1'b1; bus.m0_addr = 32'h60; bus.s_ack = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      n_chk++; if (bus.m0_ack !== 1'b0 || bus.s_req !== 1'b1) begin
        n_bad++; $display("FAIL to_wait%0d got=a0%b req%b exp=0 1", c, bus.m0_ack, bus.s_req); end
    end
    step();
    n_chk++; if (bus.m0_ack !== 1'b1 || bus.m_rdata !== 32'hDEAD_BEEF || bus.err !== 1'b1 || bus.s_req !== 1'b0) begin
      n_bad++; $display("FAIL to_abort got=a0%b d%h err%b req%b exp=1 deadbeef 1 0", bus.m0_ack, bus.m_rdata, bus.err, bus.s_req); end
    bus.m0_req = 1'b0;
    step();
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h70;
    step();
    bus.s_ack = 1'b1;
    step();
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.s_ack = 1'b0;
    step();
    n_chk++; if (bus.err !== 1'b1 || bus.m_rdata !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL to_sticky got=err%b d%h exp=1 deadbeef", bus.err, bus.m_rdata); end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_wait();
    test_reset_mid();
    test_idle_ack();
`ifdef SM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Acks are mutually exclusive at all times
  always @(negedge clk) begin
    if (rst_n && bus.m0_ack === 1'b1 && bus.m1_ack === 1'b1) begin
      n_bad++;
      $display("FAIL dual_ack got=11 exp=not both");
    end
  end
endmodule
